// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: transfer-mode encodings, ACK status codes,
// FSM state type and the TM/AD-to-byte-enable decode.
package nubus_pkg;

  // Transfer mode as seen on the bus pins {/TM1, /TM0, /AD1, /AD0}; /TM1 low = write.
  localparam logic [3:0] TMADN_W_BYTE3 = 4'b0000;
  localparam logic [3:0] TMADN_W_HALF1 = 4'b0001;
  localparam logic [3:0] TMADN_W_BLOCK = 4'b0010;
  localparam logic [3:0] TMADN_W_BYTE2 = 4'b0011;
  localparam logic [3:0] TMADN_W_BYTE1 = 4'b0100;
  localparam logic [3:0] TMADN_W_HALF0 = 4'b0101;
  localparam logic [3:0] TMADN_W_BYTE0 = 4'b0110;
  localparam logic [3:0] TMADN_W_WORD  = 4'b0111;
  localparam logic [3:0] TMADN_R_BYTE3 = 4'b1000;
  localparam logic [3:0] TMADN_R_HALF1 = 4'b1001;
  localparam logic [3:0] TMADN_R_BLOCK = 4'b1010;
  localparam logic [3:0] TMADN_R_BYTE2 = 4'b1011;
  localparam logic [3:0] TMADN_R_BYTE1 = 4'b1100;
  localparam logic [3:0] TMADN_R_HALF0 = 4'b1101;
  localparam logic [3:0] TMADN_R_BYTE0 = 4'b1110;
  localparam logic [3:0] TMADN_R_WORD  = 4'b1111;

  // ACK status as driven on {/TM1, /TM0}.
  localparam logic [1:0] TMN_COMPLETE        = 2'b11;
  localparam logic [1:0] TMN_ERROR           = 2'b10;
  localparam logic [1:0] TMN_TIMEOUT         = 2'b01;
  localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b00;

  typedef enum logic [2:0] {IDLE, WDATA, MEMREQ, RESP, END} state_t;

  // Returns {valid, be[3:0]}; block transfers are reported as not valid.
  function automatic logic [4:0] tmadn_to_be(input logic [3:0] tmadn);
    logic [4:0] r;
    r = 5'b0_0000;
    case (tmadn)
      TMADN_W_WORD,  TMADN_R_WORD:  r = 5'b1_1111;
      TMADN_W_HALF0, TMADN_R_HALF0: r = 5'b1_0011;
      TMADN_W_HALF1, TMADN_R_HALF1: r = 5'b1_1100;
      TMADN_W_BYTE0, TMADN_R_BYTE0: r = 5'b1_0001;
      TMADN_W_BYTE1, TMADN_R_BYTE1: r = 5'b1_0010;
      TMADN_W_BYTE2, TMADN_R_BYTE2: r = 5'b1_0100;
      TMADN_W_BYTE3, TMADN_R_BYTE3: r = 5'b1_1000;
      default:                      r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nubus_slave_decode.sv
// Start-cycle decode: slot address match, direction, byte enables, word address.
// Optional NUBUS_SLAVE_SUPERSLOT_EN adds super-slot (sXXXXXXX) matching.
module nubus_slave_decode
  import nubus_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic [3:0]        id_n,
  input  logic              tm1_n,
  input  logic              tm0_n,
  input  logic [31:0]       ad_n,
  output logic              match,
  output logic              we,
  output logic              valid,
  output logic [3:0]        be,
  output logic [ADDR_W-1:0] addr
);

  logic [31:2] ad;
  logic [3:0]  id;
  logic [4:0]  vbe;

  assign ad = ~ad_n[31:2];
  assign id = ~id_n;

  // NOTE: every output gets a default at the top so no path can infer a latch.
  always_comb begin
    vbe   = tmadn_to_be({tm1_n, tm0_n, ad_n[1:0]});
    valid = vbe[4];
    be    = vbe[3:0];
    we    = ~tm1_n;
    match = (ad[31:24] == {4'hF, id});
`ifdef NUBUS_SLAVE_SUPERSLOT_EN
    // Bit 29 distinguishes super-slot from standard-slot accesses.
    addr = ADDR_W'({1'b0, ad[30:2]});
    if (!match && (ad[31:28] == id)) begin
      match = 1'b1;
      addr  = ADDR_W'({1'b1, 3'b000, ad[27:2]});
    end
`else
    addr = ADDR_W'(ad[31:2]);
`endif
  end

endmodule

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave transaction engine: start decode, local-bus request/ack, ACK response.
// Define NUBUS_SLAVE_SUPERSLOT_EN to also answer in super-slot space.
module nubus_slave_ctrl
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 30
) (
  input  logic              clk_3v3_n,
  input  logic              reset_3v3_n,
  input  logic [3:0]        id_3v3_n,
  input  logic              start_3v3_n,
  input  logic              ack_3v3_n,
  input  logic              tm0_3v3_n,
  input  logic              tm1_3v3_n,
  input  logic [31:0]       ad_3v3_n,
  output logic [31:0]       ad_o_n,
  output logic              nubus_ad_dir,
  output logic              ack_o_n,
  output logic              ack_oe_n,
  output logic              tm0_o_n,
  output logic              tm1_o_n,
  output logic              tmx_oe_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         status;
  logic [31:0]        rdata;
  logic               dec_match, dec_we, dec_valid;
  logic [3:0]         dec_be;
  logic [ADDR_W-1:0]  dec_addr;
  logic               start_ok, timeout, resp, drive;

  nubus_slave_decode #(.ADDR_W(ADDR_W)) u_decode (
    .id_n  (id_3v3_n),
    .tm1_n (tm1_3v3_n),
    .tm0_n (tm0_3v3_n),
    .ad_n  (ad_3v3_n),
    .match (dec_match),
    .we    (dec_we),
    .valid (dec_valid),
    .be    (dec_be),
    .addr  (dec_addr)
  );

  // START with ACK also asserted is an attention cycle, not a transaction.
  assign start_ok = !start_3v3_n && ack_3v3_n && dec_match;
  assign timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_3v3_n or negedge reset_3v3_n) begin
    if (!reset_3v3_n) begin
      state     <= IDLE;
      cnt       <= '0;
      status    <= TMN_COMPLETE;
      rdata     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start_ok) begin
          mem_we   <= dec_we;
          mem_addr <= dec_addr;
          mem_be   <= dec_be;
          cnt      <= '0;
          status   <= dec_valid ? TMN_COMPLETE : TMN_ERROR;
        end
        WDATA: mem_wdata <= ~ad_3v3_n;
        MEMREQ: begin
          if (mem_ack) begin
            status <= TMN_COMPLETE;
            if (!mem_we) rdata <= mem_rdata;
          end else if (timeout) begin
            status <= TMN_TRY_AGAIN_LATER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_ok) begin
        if (!dec_valid)  state_nx = RESP;
        else if (dec_we) state_nx = WDATA;
        else             state_nx = MEMREQ;
      end
      WDATA:   state_nx = MEMREQ;
      MEMREQ:  if (mem_ack || timeout) state_nx = RESP;
      RESP:    state_nx = END;
      END:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Drivers decode straight from state so an async reset releases them at once.
  assign resp               = (state == RESP);
  assign drive              = resp && !mem_we && (status == TMN_COMPLETE);
  assign mem_req            = (state == MEMREQ);
  assign busy               = (state == WDATA) || (state == MEMREQ) || resp;
  assign ack_o_n            = !resp;
  assign ack_oe_n           = !resp;
  assign tmx_oe_n           = !resp;
  assign {tm1_o_n, tm0_o_n} = resp ? status : 2'b11;
  assign nubus_ad_dir       = drive;
  assign ad_o_n             = drive ? ~rdata : '1;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Self-checking bench for nubus_slave_ctrl (default build, slot ID C, short timeout).
module tb_nubus_slave_ctrl;
  import nubus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_n;
  logic        start_n, ack_n, tm0_n, tm1_n;
  logic [31:0] ad_n;
  logic [31:0] ad_o_n;
  logic        nubus_ad_dir, ack_o_n, ack_oe_n, tm0_o_n, tm1_o_n, tmx_oe_n;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  status;
    logic        drive;
    logic [31:0] ad;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  nubus_slave_ctrl #(.TIMEOUT_CYCLES(8), .ADDR_W(30)) dut (
    .clk_3v3_n    (clk),
    .reset_3v3_n  (rst_n),
    .id_3v3_n     (id_n),
    .start_3v3_n  (start_n),
    .ack_3v3_n    (ack_n),
    .tm0_3v3_n    (tm0_n),
    .tm1_3v3_n    (tm1_n),
    .ad_3v3_n     (ad_n),
    .ad_o_n       (ad_o_n),
    .nubus_ad_dir (nubus_ad_dir),
    .ack_o_n      (ack_o_n),
    .ack_oe_n     (ack_oe_n),
    .tm0_o_n      (tm0_o_n),
    .tm1_o_n      (tm1_o_n),
    .tmx_oe_n     (tmx_oe_n),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [31:0] addr, input logic [3:0] tmadn);
    start_n = 1'b0;
    tm1_n   = tmadn[3];
    tm0_n   = tmadn[2];
    ad_n    = {~addr[31:2], tmadn[1:0]};
  endtask

  // Quiet-bus snapshot: {ack_o_n, ack_oe_n, tmx_oe_n, tm1_o_n, tm0_o_n, dir, req, we, busy}
  function automatic logic [8:0] ctl_snap();
    return {ack_o_n, ack_oe_n, tmx_oe_n, tm1_o_n, tm0_o_n, nubus_ad_dir, mem_req, mem_we, busy};
  endfunction

  // Runs one addressed transaction; ack_after < 0 means mem_ack is never given.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [3:0] tmadn,
                         input logic [31:0] data, input logic [3:0] exp_be, input int ack_after,
                         input logic [1:0] exp_status, input int exp_ack_cyc, input int exp_req_cyc);
    exp_t e, h;
    int   req_cyc;
    bit   done;
    e.we     = ~tmadn[3];
    e.addr   = addr[31:2];
    e.be     = exp_be;
    e.wdata  = data;
    e.status = exp_status;
    e.drive  = tmadn[3] && (exp_status == TMN_COMPLETE);
    e.ad     = e.drive ? ~data : 32'hFFFF_FFFF;
    exp_q.push_back(e);

    drive_start(addr, tmadn);
    tick();
    start_n   = 1'b1;
    tm1_n     = 1'b1;
    tm0_n     = 1'b1;
    ad_n      = e.we ? ~data : 32'hFFFF_FFFF;
    mem_rdata = data;
    req_cyc   = 0;
    done      = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (mem_req) begin
        if (req_cyc == 0) begin
          h = exp_q[0];
          checks++;
          if ({mem_we, mem_addr, mem_be} !== {h.we, h.addr, h.be}) begin
            errors++;
            $display("FAIL %s mem_cmd: got we=%b addr=%h be=%b, expected we=%b addr=%h be=%b",
                     name, mem_we, mem_addr, mem_be, h.we, h.addr, h.be);
          end
          if (h.we) begin
            checks++;
            if (mem_wdata !== h.wdata) begin
              errors++;
              $display("FAIL %s mem_wdata: got %h expected %h", name, mem_wdata, h.wdata);
            end
          end
        end
        mem_ack = (req_cyc == ack_after);
        req_cyc++;
      end else begin
        mem_ack = 1'b0;
      end

      if (!ack_oe_n) begin
        h = exp_q.pop_front();
        checks++;
        if ({ack_o_n, tmx_oe_n, tm1_o_n, tm0_o_n} !== {2'b00, h.status}) begin
          errors++;
          $display("FAIL %s ack_status: got ack=%b tmx_oe=%b tm=%b expected ack=0 tmx_oe=0 tm=%b",
                   name, ack_o_n, tmx_oe_n, {tm1_o_n, tm0_o_n}, h.status);
        end
        checks++;
        if ({nubus_ad_dir, ad_o_n} !== {h.drive, h.ad}) begin
          errors++;
          $display("FAIL %s ack_data: got dir=%b ad_o_n=%h expected dir=%b ad_o_n=%h",
                   name, nubus_ad_dir, ad_o_n, h.drive, h.ad);
        end
        checks++;
        if (cyc != exp_ack_cyc || req_cyc != exp_req_cyc) begin
          errors++;
          $display("FAIL %s timing: got ack_cycle=%0d req_cycles=%0d expected %0d/%0d",
                   name, cyc, req_cyc, exp_ack_cyc, exp_req_cyc);
        end
        tick();
        checks++;
        if ({ack_oe_n, tmx_oe_n, nubus_ad_dir, busy, mem_req, ad_o_n} !== {5'b11000, 32'hFFFF_FFFF}) begin
          errors++;
          $display("FAIL %s release: got ack_oe=%b tmx_oe=%b dir=%b busy=%b req=%b ad_o_n=%h expected 1 1 0 0 0 ffffffff",
                   name, ack_oe_n, tmx_oe_n, nubus_ad_dir, busy, mem_req, ad_o_n);
        end
        done = 1'b1;
      end else begin
        tick();
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s ack_wait: got no ACK within 40 cycles, expected ACK at cycle %0d", name, exp_ack_cyc);
      void'(exp_q.pop_front());
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    id_n      = ~4'hC;
    start_n   = 1'b1;
    ack_n     = 1'b1;
    tm0_n     = 1'b1;
    tm1_n     = 1'b1;
    ad_n      = 32'hFFFF_FFFF;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) tick();
    checks++;
    if (ctl_snap() !== 9'b11111_0000 || ad_o_n !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_ctl: got %b ad_o_n=%h expected 111110000 ffffffff", ctl_snap(), ad_o_n);
    end
    checks++;
    if ({mem_addr, mem_be, mem_wdata} !== 66'h0) begin
      errors++;
      $display("FAIL reset_mem: got addr=%h be=%b wdata=%h expected all zero", mem_addr, mem_be, mem_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    run_txn("write_word", 32'hFC00_0000, TMADN_W_WORD, 32'h8765_4321, 4'b1111, 1, TMN_COMPLETE, 4, 2);
    run_txn("read_half1", 32'hFC00_0008, TMADN_R_HALF1, 32'h8765_4321, 4'b1100, 0, TMN_COMPLETE, 2, 1);
    run_txn("write_byte2", 32'hFC00_0014, TMADN_W_BYTE2, 32'h00AB_0000, 4'b0100, 0, TMN_COMPLETE, 3, 1);
    run_txn("read_byte0", 32'hFC00_000C, TMADN_R_BYTE0, 32'h0000_005A, 4'b0001, 2, TMN_COMPLETE, 4, 3);
  endtask

  task automatic test_other_slot();
    bit bad = 1'b0;
    drive_start(32'hFB00_0000, TMADN_R_WORD);
    tick();
    start_n = 1'b1;
    tm1_n   = 1'b1;
    tm0_n   = 1'b1;
    ad_n    = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      if (mem_req || !ack_oe_n || busy) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL other_slot: got a response to slot B access, expected req=0 ack_oe=1 busy=0");
    end
  endtask

  task automatic test_errors();
    run_txn("timeout", 32'hFC00_0010, TMADN_R_WORD, 32'h1234_5678, 4'b1111, -1, TMN_TRY_AGAIN_LATER, 9, 8);
    run_txn("block", 32'hFC00_0020, TMADN_R_BLOCK, 32'h0, 4'b0000, -1, TMN_ERROR, 1, 0);
  endtask

  task automatic test_reset_abort();
    drive_start(32'hFC00_0000, TMADN_R_WORD);
    tick();
    start_n = 1'b1;
    tm1_n   = 1'b1;
    tm0_n   = 1'b1;
    ad_n    = 32'hFFFF_FFFF;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: got mem_req=%b expected 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ctl_snap() !== 9'b11111_0000 || ad_o_n !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL abort_async: got %b ad_o_n=%h expected 111110000 ffffffff", ctl_snap(), ad_o_n);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_txn("after_reset", 32'hFC00_0000, TMADN_R_WORD, 32'hCAFE_F00D, 4'b1111, 0, TMN_COMPLETE, 2, 1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_other_slot();
    test_errors();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nubus_slave_ctrl.md
Name: nubus_slave_ctrl

Overview:
- Slave-side NuBus transaction engine between the CPLD/level-shifter front end (3v3 NuBus signals) and the card's local memory/register bus.
- Detects start cycles addressed to this slot and decodes TM/AD[1:0] into read/write, byte enables and a word address.
- Runs a request/ack handshake on the local bus, then drives ACK with a TM status code and read data back onto NuBus.

Parameters:
- TIMEOUT_CYCLES, 255: local-bus cycles to wait for mem_ack before answering try-again-later.
- ADDR_W, 30: width of mem_addr (word address, AD[31:2]).

Ports:
- clk_3v3_n  in  1  NuBus clock from CPLD. All state updates on its rising edge.
- reset_3v3_n  in  1  asynchronous active-low reset.
- id_3v3_n  in  4  slot ID, active-low.
- start_3v3_n  in  1  NuBus /START.
- ack_3v3_n  in  1  NuBus /ACK, monitored only.
- tm0_3v3_n, tm1_3v3_n  in  1 each  NuBus /TM0, /TM1.
- ad_3v3_n  in  32  NuBus /AD, input side.
- ad_o_n  out  32  read data to drive, active-low.
- nubus_ad_dir  out  1  1 = card drives AD.
- ack_o_n, ack_oe_n  out  1 each  ACK value and enable, active-low.
- tm0_o_n, tm1_o_n, tmx_oe_n  out  1 each  status value and enable.
- mem_req  out  1  local request, held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_be  out  4  byte enables, bit k = byte lane k.
- mem_wdata  out  32  write data, true polarity.
- mem_rdata  in  32  read data.
- mem_ack  in  1  single-cycle completion.
- busy  out  1  transaction in progress.

Behaviour:
- Reset:
  - All *_oe_n, ack_o_n, tm*_o_n = 1.
  - ad_o_n = all ones.
  - nubus_ad_dir, mem_req, mem_we, busy = 0.
  - mem_be = 0, mem_addr = 0, mem_wdata = 0.
  - FSM = IDLE.
- Address match: true when ~ad[31:24] == {4'hF, ~id_3v3_n}, i.e. standard slot space Fs.
- Write/read decode: write when tm1n = 0.
- Byte enables from {tm1n, tm0n, ad1n, ad0n} using the package TMADN_* constants:
  - word -> 1111
  - half0 -> 0011, half1 -> 1100
  - byte k -> one-hot bit k
  - any block-transfer encoding -> unsupported.
- FSM states: IDLE, WDATA, MEMREQ, RESP, END.
- IDLE:
  - start_3v3_n = 0 and match -> latch address, be and we; busy = 1.
  - Write -> WDATA. Read -> MEMREQ.
  - Unsupported encoding -> RESP with status ERROR, no mem_req.
  - No match -> stay in IDLE, drive nothing.
- WDATA (one cycle after start): latch mem_wdata = ~ad_3v3_n -> MEMREQ.
- MEMREQ:
  - mem_req = 1 until mem_ack.
  - On mem_ack: capture mem_rdata for reads -> RESP with COMPLETE.
  - Counter reaching TIMEOUT_CYCLES -> drop mem_req, RESP with TRY_AGAIN_LATER.
  - mem_ack and timeout in the same cycle: mem_ack wins.
- RESP (exactly one cycle):
  - ack_o_n = 0; tm1_o_n/tm0_o_n = status; ack_oe_n = tmx_oe_n = 0.
  - Reads with COMPLETE: nubus_ad_dir = 1, ad_o_n = ~rdata.
- END (one cycle): release all enables and drivers -> IDLE; busy = 0.
- Latency: minimum start-to-ACK is 2 cycles (read, mem_ack in its first MEMREQ cycle); writes add 1.
- A start received outside IDLE is ignored. The bus owner guarantees none occur.
- Reset mid-transaction:
  - Asynchronously releases every driver and mem_req within the same clock.
  - No ACK is produced. Master timeout covers the aborted cycle.

Optional Feature:
- NUBUS_SLAVE_SUPERSLOT_EN defined: also match super-slot space, ~ad[31:28] == ~id_3v3_n (s0000000–sFFFFFFF). mem_addr then carries the full 28-bit offset, with bit 29 = 1 marking super-slot.
- Undefined: only Fs space matches; bit 29 = 0.

Decomposition:
- Package nubus_pkg:
  - TMADN_* transfer-mode constants.
  - TMN_COMPLETE/ERROR/TIMEOUT/TRY_AGAIN_LATER status codes.
  - FSM state enum.
  - Function tmadn_to_be(4-bit) -> {valid, be[3:0]}.
- Sub-module nubus_slave_decode (combinational): address match plus TM/AD decode, feeding the FSM.

Test Plan:
- ID = C, write word to FC000000 with data 87654321, mem_ack after 1 cycle -> mem_we = 1, mem_addr = 3F000000 (word address), mem_be = 1111, mem_wdata = 87654321; ACK with TMN_COMPLETE.
- Read half1 at FC000008, mem_rdata = 87654321 -> mem_be = 1100; ad_o_n = ~87654321 during the ACK cycle; nubus_ad_dir = 1 for that cycle only.
- Write byte 2 at FC000014 -> mem_be = 0100; read byte 0 -> mem_be = 0001.
- Read at FB000000 (other slot) -> no mem_req, ack_oe_n stays 1, busy stays 0.
- TIMEOUT_CYCLES = 8, mem_ack never asserted -> mem_req drops after 8 cycles; ACK with TMN_TRY_AGAIN_LATER. A block-mode TM encoding -> ACK with TMN_ERROR and no mem_req.
- Assert reset_3v3_n low during MEMREQ -> mem_req, all *_oe_n and nubus_ad_dir return to reset values immediately; the next start to FC000000 completes normally.
